crossbar_2x2_sched: RTL and testbench
=====================================

Name: crossbar_2x2_sched

Overview:
Scheduler and output stage for the team's 2x2 4-bit crossbar cell. Two requesters each present a 4-bit word plus a destination bit. The block resolves output contention with round-robin priority, drives the crossbar control bit, and registers the routed words into two output ports with valid/ready backpressure. It sits between the two source ports and the two sink ports of the switch.

Parameters:
DW, 4, data width per port (crossbar cell width)
CW, 8, width of saturating conflict counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
in1_valid  input  1  requester 1 has a word
in1_dest  input  1  requester 1 target: 0=out1, 1=out2
in1_data  input  DW  requester 1 word
in1_ready  output  1  requester 1 word accepted this cycle
in2_valid  input  1  requester 2 has a word
in2_dest  input  1  requester 2 target: 0=out1, 1=out2
in2_data  input  DW  requester 2 word
in2_ready  output  1  requester 2 word accepted this cycle
out1_valid  output  1  out1 register holds a word
out1_data  output  DW  out1 word
out1_ready  input  1  sink 1 consumes word
out2_valid  output  1  out2 register holds a word
out2_data  output  DW  out2 word
out2_ready  input  1  sink 2 consumes word
xbar_ctrl  output  1  crossbar setting of last transfer: 0=straight (in1->out1, in2->out2), 1=cross (in1->out2, in2->out1)
conflict_cnt  output  CW  cycles with same-destination contention, saturating

Behaviour:
- Reset (rst_n=0 at posedge clk): out1_valid=0, out2_valid=0, out1_data=0, out2_data=0, xbar_ctrl=0, conflict_cnt=0, rr_ptr=0 (in1 has priority). Reset is synchronous and overrides any transfer in the same cycle. Words held in the output registers are discarded.
- Output k is available when out_k_valid=0 or out_k_ready=1. This allows full throughput, one word per output per cycle.
- Grant rules (combinational, same cycle):
  - Single valid requester: granted if its destination is available.
  - Both valid, different destinations: each is granted independently if its destination is available.
  - Both valid, same destination (conflict): only the rr_ptr requester (0=in1, 1=in2) is eligible, and it is granted if the destination is available. The other requester gets ready=0.
- in_k_ready = grant_k. in_k_ready must not depend combinationally on in_k_ready itself. It may depend on valid, dest, out_ready and state.
- Requester contract: valid, dest and data stay stable until ready. The bench checks this and the DUT does not.
- Transfer latency is 1 cycle. A word granted in cycle N appears at out_dest with valid=1 after posedge N+1.
- Drain: if out_k_ready=1 and no new grant to output k, out_k_valid clears next cycle. If out_k_valid=1 and out_k_ready=0, data holds.
- rr_ptr toggles only in a cycle where a conflict is resolved by a grant. It does not toggle on a stalled conflict or on non-conflicting traffic.
- xbar_ctrl is registered and updates only on cycles with at least one grant. Otherwise it holds.
  - in1 granted: xbar_ctrl = in1_dest.
  - Only in2 granted: xbar_ctrl = ~in2_dest.
- conflict_cnt increments by 1 in every cycle with in1_valid & in2_valid & (in1_dest==in2_dest), whether or not a grant occurs. It saturates at 2^CW-1.
- No combinational path from in*_data to out*_data.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with all inputs active -> all outputs 0, in1_ready=in2_ready=0 is not required, but no output register loads.
- Straight and cross routing: in1=3/dest0, in2=5/dest1, both sinks ready -> next cycle out1=3, out2=5, xbar_ctrl=0. Then in1=3/dest1, in2=5/dest0 -> out1=5, out2=3, xbar_ctrl=1.
- Round-robin contention: both valid dest0, in1=4'hA, in2=4'hB, out1_ready=1 for 4 cycles -> out1 sequence A,B,A,B (after re-presenting), ready alternates in1,in2, conflict_cnt=4.
- Backpressure: out1_ready=0 with out1_valid=1 and in1 valid dest0 -> in1_ready=0 and out1_data held. Raise out1_ready -> grant in the same cycle and new word next cycle (no bubble).
- Stalled conflict: both dest1, out2 full and not ready for 3 cycles -> rr_ptr unchanged, conflict_cnt +3. On release, the rr_ptr requester wins.
- Saturation and mid-operation reset: CW=2, hold a conflict for 6 cycles -> conflict_cnt stays at 3. Assert rst_n=0 with out valid -> out valid=0 next cycle, rr_ptr=0.

Source files
------------

// File: rtl/crossbar_2x2_sched.sv
// Scheduler and output stage for the 2x2 crossbar cell: round-robin contention
// resolution, crossbar control and registered output ports with valid/ready.
module crossbar_2x2_sched #(
  parameter int DW = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in1_valid,
  input  logic          in1_dest,
  input  logic [DW-1:0] in1_data,
  output logic          in1_ready,
  input  logic          in2_valid,
  input  logic          in2_dest,
  input  logic [DW-1:0] in2_data,
  output logic          in2_ready,
  output logic          out1_valid,
  output logic [DW-1:0] out1_data,
  input  logic          out1_ready,
  output logic          out2_valid,
  output logic [DW-1:0] out2_data,
  input  logic          out2_ready,
  output logic          xbar_ctrl,
  output logic [CW-1:0] conflict_cnt
);

  logic          r_out1_valid;
  logic          r_out2_valid;
  logic [DW-1:0] r_out1_data;
  logic [DW-1:0] r_out2_data;
  logic          r_xbar_ctrl;
  logic [CW-1:0] r_conflict_cnt;
  logic          r_rr_ptr;

  logic          w_avail1;
  logic          w_avail2;
  logic          w_conflict;
  logic          w_grant1;
  logic          w_grant2;
  logic          w_ld1;
  logic          w_ld2;
  logic [DW-1:0] w_ld1_data;
  logic [DW-1:0] w_ld2_data;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + {{(CW-1){1'b0}}, 1'b1};
  endfunction

  // An output can take a word when empty or when its current word leaves this cycle.
  assign w_avail1   = ~r_out1_valid | out1_ready;
  assign w_avail2   = ~r_out2_valid | out2_ready;
  assign w_conflict = in1_valid & in2_valid & (in1_dest == in2_dest);

  assign w_grant1 = in1_valid & ~(w_conflict & r_rr_ptr)
                  & (in1_dest ? w_avail2 : w_avail1);
  assign w_grant2 = in2_valid & ~(w_conflict & ~r_rr_ptr)
                  & (in2_dest ? w_avail2 : w_avail1);

  // At most one grant targets each output, so a simple select picks the source.
  assign w_ld1      = (w_grant1 & ~in1_dest) | (w_grant2 & ~in2_dest);
  assign w_ld2      = (w_grant1 &  in1_dest) | (w_grant2 &  in2_dest);
  assign w_ld1_data = (w_grant1 & ~in1_dest) ? in1_data : in2_data;
  assign w_ld2_data = (w_grant1 &  in1_dest) ? in1_data : in2_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out1_valid   <= 1'b0;
      r_out2_valid   <= 1'b0;
      r_out1_data    <= '0;
      r_out2_data    <= '0;
      r_xbar_ctrl    <= 1'b0;
      r_conflict_cnt <= '0;
      r_rr_ptr       <= 1'b0;
    end else begin
      if (w_ld1) begin
        r_out1_valid <= 1'b1;
        r_out1_data  <= w_ld1_data;
      end else if (out1_ready) begin
        r_out1_valid <= 1'b0;
      end
      if (w_ld2) begin
        r_out2_valid <= 1'b1;
        r_out2_data  <= w_ld2_data;
      end else if (out2_ready) begin
        r_out2_valid <= 1'b0;
      end
      if (w_grant1) begin
        r_xbar_ctrl <= in1_dest;
      end else if (w_grant2) begin
        r_xbar_ctrl <= ~in2_dest;
      end
      // Priority only rotates when a contended output actually accepts a word.
      if (w_conflict & (w_grant1 | w_grant2)) begin
        r_rr_ptr <= ~r_rr_ptr;
      end
      if (w_conflict) begin
        r_conflict_cnt <= sat_inc(r_conflict_cnt);
      end
    end
  end

  assign in1_ready    = w_grant1;
  assign in2_ready    = w_grant2;
  assign out1_valid   = r_out1_valid;
  assign out2_valid   = r_out2_valid;
  assign out1_data    = r_out1_data;
  assign out2_data    = r_out2_data;
  assign xbar_ctrl    = r_xbar_ctrl;
  assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_crossbar_2x2_sched.sv
// Directed bench for crossbar_2x2_sched: a reference model predicts grants and
// state, and per-output queues hold the words each sink is expected to receive.
module tb_crossbar_2x2_sched;

  logic       clk;
  logic       rst_n;
  logic       in1_valid, in1_dest, in2_valid, in2_dest;
  logic [3:0] in1_data, in2_data;
  logic       out1_ready, out2_ready;

  logic       in1_ready, in2_ready, out1_valid, out2_valid, xbar_ctrl;
  logic [3:0] out1_data, out2_data;
  logic [7:0] conflict_cnt;

  logic       s_in1_ready, s_in2_ready, s_out1_valid, s_out2_valid, s_xbar_ctrl;
  logic [3:0] s_out1_data, s_out2_data;
  logic [1:0] s_conflict_cnt;

  int checks = 0;
  int errors = 0;

  logic       m_v1, m_v2, m_xbar, m_rr;
  logic [7:0] m_cnt;
  logic [1:0] m_cnt2;
  logic [3:0] q1[$];
  logic [3:0] q2[$];

  crossbar_2x2_sched #(.DW(4), .CW(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in1_valid(in1_valid), .in1_dest(in1_dest), .in1_data(in1_data), .in1_ready(in1_ready),
    .in2_valid(in2_valid), .in2_dest(in2_dest), .in2_data(in2_data), .in2_ready(in2_ready),
    .out1_valid(out1_valid), .out1_data(out1_data), .out1_ready(out1_ready),
    .out2_valid(out2_valid), .out2_data(out2_data), .out2_ready(out2_ready),
    .xbar_ctrl(xbar_ctrl), .conflict_cnt(conflict_cnt)
  );

  crossbar_2x2_sched #(.DW(4), .CW(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .in1_valid(in1_valid), .in1_dest(in1_dest), .in1_data(in1_data), .in1_ready(s_in1_ready),
    .in2_valid(in2_valid), .in2_dest(in2_dest), .in2_data(in2_data), .in2_ready(s_in2_ready),
    .out1_valid(s_out1_valid), .out1_data(s_out1_data), .out1_ready(out1_ready),
    .out2_valid(s_out2_valid), .out2_data(s_out2_data), .out2_ready(out2_ready),
    .xbar_ctrl(s_xbar_ctrl), .conflict_cnt(s_conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v1, input logic d1, input logic [3:0] w1,
                       input logic v2, input logic d2, input logic [3:0] w2,
                       input logic r1, input logic r2);
    in1_valid = v1; in1_dest = d1; in1_data = w1;
    in2_valid = v2; in2_dest = d2; in2_data = w2;
    out1_ready = r1; out2_ready = r2;
  endtask

  // One clock cycle: predict and check grants mid-cycle, then check registers after the edge.
  task automatic step();
    logic g1, g2, conf, av1, av2;
    logic [3:0] exp;
    #4;
    if (rst_n) begin
      av1  = !m_v1 || out1_ready;
      av2  = !m_v2 || out2_ready;
      conf = in1_valid && in2_valid && (in1_dest == in2_dest);
      g1 = in1_valid && (in1_dest ? av2 : av1) && !(conf && m_rr);
      g2 = in2_valid && (in2_dest ? av2 : av1) && !(conf && !m_rr);
      chk("in1_ready", 32'(in1_ready), 32'(g1));
      chk("in2_ready", 32'(in2_ready), 32'(g2));
      chk("sat_in1_ready", 32'(s_in1_ready), 32'(g1));
      chk("sat_in2_ready", 32'(s_in2_ready), 32'(g2));
      if (m_v1 && out1_ready) begin
        exp = q1.pop_front();
        chk("out1_data_consumed", 32'(out1_data), 32'(exp));
        chk("sat_out1_data_consumed", 32'(s_out1_data), 32'(exp));
        m_v1 = 1'b0;
      end
      if (m_v2 && out2_ready) begin
        exp = q2.pop_front();
        chk("out2_data_consumed", 32'(out2_data), 32'(exp));
        chk("sat_out2_data_consumed", 32'(s_out2_data), 32'(exp));
        m_v2 = 1'b0;
      end
      if (g1) begin
        if (in1_dest) begin q2.push_back(in1_data); m_v2 = 1'b1; end
        else          begin q1.push_back(in1_data); m_v1 = 1'b1; end
      end
      if (g2) begin
        if (in2_dest) begin q2.push_back(in2_data); m_v2 = 1'b1; end
        else          begin q1.push_back(in2_data); m_v1 = 1'b1; end
      end
      if (conf && (g1 || g2)) m_rr = !m_rr;
      if (g1)      m_xbar = in1_dest;
      else if (g2) m_xbar = !in2_dest;
      if (conf) begin
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
      end
    end else begin
      q1.delete(); q2.delete();
      m_v1 = 1'b0; m_v2 = 1'b0; m_xbar = 1'b0; m_rr = 1'b0;
      m_cnt = 8'd0; m_cnt2 = 2'd0;
    end
    @(posedge clk);
    #1;
    chk("out1_valid", 32'(out1_valid), 32'(m_v1));
    chk("out2_valid", 32'(out2_valid), 32'(m_v2));
    chk("xbar_ctrl", 32'(xbar_ctrl), 32'(m_xbar));
    chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
    chk("sat_out1_valid", 32'(s_out1_valid), 32'(m_v1));
    chk("sat_out2_valid", 32'(s_out2_valid), 32'(m_v2));
    chk("sat_xbar_ctrl", 32'(s_xbar_ctrl), 32'(m_xbar));
    chk("sat_conflict_cnt", 32'(s_conflict_cnt), 32'(m_cnt2));
    if (!rst_n) begin
      chk("out1_data_reset", 32'(out1_data), 32'd0);
      chk("out2_data_reset", 32'(out2_data), 32'd0);
    end
    if (m_v1) chk("out1_data_held", 32'(out1_data), 32'(q1[0]));
    if (m_v2) chk("out2_data_held", 32'(out2_data), 32'(q2[0]));
  endtask

  initial begin
    m_v1 = 1'b0; m_v2 = 1'b0; m_xbar = 1'b0; m_rr = 1'b0;
    m_cnt = 8'd0; m_cnt2 = 2'd0;

    // Reset held for two cycles with every input active.
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 4'hE, 1'b1, 1'b1);
    step(); step();
    rst_n = 1'b1;

    // Straight then cross routing, then drain.
    drive(1'b1, 1'b0, 4'h3, 1'b1, 1'b1, 4'h5, 1'b1, 1'b1); step();
    drive(1'b1, 1'b1, 4'h3, 1'b1, 1'b0, 4'h5, 1'b1, 1'b1); step();
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1); step();

    // Round-robin contention on out1: A,B,A,B with both requesters re-presenting.
    drive(1'b1, 1'b0, 4'hA, 1'b1, 1'b0, 4'hB, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step();
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1); step();

    // Backpressure on out1, then release with a same-cycle grant.
    drive(1'b1, 1'b0, 4'h7, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1); step();
    drive(1'b1, 1'b0, 4'h9, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1); step(); step();
    drive(1'b1, 1'b0, 4'h9, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1); step();
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1); step();

    // Stalled conflict on a full out2, then release.
    drive(1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1); step();
    drive(1'b1, 1'b1, 4'h2, 1'b1, 1'b1, 4'h3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step();
    drive(1'b1, 1'b1, 4'h2, 1'b1, 1'b1, 4'h3, 1'b1, 1'b1); step();
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h3, 1'b1, 1'b1); step();
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1); step();

    // Mid-operation reset with a word held in out1; in1 must win afterwards.
    drive(1'b1, 1'b0, 4'hC, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1); step();
    rst_n = 1'b0; step();
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 4'h6, 1'b1, 1'b0, 4'h8, 1'b1, 1'b1); step(); step();
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
